rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (wr/addr3/data3) between two writeback sources.
//    - Port 0: ALU result.
//    - Port 1: load data.
//  Each port has a 1-entry holding slot with a valid/ready handshake.
//  Slots are granted in age order; ties are broken round-robin. At most one register-file write per cycle.
//  Also reports pending-write hazards on the two read addresses so decode can stall.
// PARAMETERS
//  AW          5   register address width
//  DW          32  register data width
//  DISCARD_R0  1   1: writes to address 0 are accepted and consumed but never drive wr
//  CNT_W       16  width of committed-write counter
// PORTS
//  clk       in   1      clock; all state updates on posedge
//  rst_n     in   1      asynchronous active-low reset
//  s0_valid  in   1      port 0 (ALU) write request
//  s0_ready  out  1      port 0 slot can accept this cycle
//  s0_addr   in   AW     port 0 destination register
//  s0_data   in   DW     port 0 write data
//  s1_valid  in   1      port 1 (load) write request
//  s1_ready  out  1      port 1 slot can accept this cycle
//  s1_addr   in   AW     port 1 destination register
//  s1_data   in   DW     port 1 write data
//  wr        out  1      register file write enable (registered)
//  addr3     out  AW     register file write address (registered)
//  data3     out  DW     register file write data (registered)
//  rd_addr1  in   AW     decode read address 1
//  rd_addr2  in   AW     decode read address 2
//  rd_pend1  out  1      write to rd_addr1 pending in a slot or on wr
//  rd_pend2  out  1      write to rd_addr2 pending in a slot or on wr
//  wr_cnt    out  CNT_W  number of cycles wr was high; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (rst_n=0, async): the following take effect immediately, independent of clk.
//    - Both slots empty; age bit = 0; rr pointer = 0 (port 0 favoured).
//    - wr=0, addr3=0, data3=0, wr_cnt=0.
//    - Consequently s0_ready = s1_ready = 1 and rd_pend1 = rd_pend2 = 0.
//  Reset mid-operation discards held requests; no partial write is issued.
//  Accept: port i is accepted on a posedge where si_valid && si_ready; the slot captures addr/data.
//  si_ready = !full_i || grant_i. A slot drained at an edge may reload at the same edge (1 req/cycle/port).
//  Grant (combinational from slot state, each cycle):
//    - One slot full: that slot is granted.
//    - Both full, different acceptance edges: the older slot is granted (per-slot age bit).
//    - Both full, accepted at the same edge: grant goes to the port pointed to by rr; rr then flips.
//    - rr changes only on a tie grant.
//  Commit: at the posedge where slot i is granted:
//    - addr3 <= slot addr; data3 <= slot data; slot empties (or reloads).
//    - wr <= 1, except wr <= 0 when DISCARD_R0 && addr==0.
//    - No grant that cycle: wr <= 0; addr3 and data3 hold their values.
//  wr is high for exactly one clock per committed write.
//  Latency: accept edge N, earliest wr high in cycle after edge N+1.
//  Ordering: writes to the same address reach the register file in acceptance order. A tie is resolved by rr.
//  Hazard flags: rd_pendK = 1 if any of the following matches rd_addrK:
//    - a full slot's addr, or
//    - addr3 while wr=1.
//  Address 0 never flags when DISCARD_R0=1. The flags are combinational from state and rd_addr only.
//  wr_cnt increments on each edge that sets wr=1; wraps from 2^CNT_W-1 to 0.
//  Throughput: sustained 1 write/cycle total. When both ports stream, each port is ready every other cycle.
// TESTING
//  1. Reset while both slots are full: wr=0, slots empty, and both ready=1 asynchronously.
//     After release, no write is issued.
//  2. s0 {addr 3, data 0x11} alone: s0_ready stays 1. In the cycle after the second edge, wr=1, addr3=3, data3=0x11.
//     rd_pend1 (rd_addr1=3) is 1 from the accept edge until wr drops.
//  3. s0 {5, 0xA} and s1 {5, 0xB} accepted at the same edge after reset:
//     - writes are 0xA then 0xB on consecutive cycles (rr=0);
//     - a repeat tie grants s1 first.
//  4. s1 {7, 0xC} accepted, then s0 {7, 0xD} one cycle later while the s1 slot is still full:
//     0xC is written before 0xD (age order).
//  5. s0 {0, 0xFF} with DISCARD_R0=1: accepted and consumed; wr stays 0; wr_cnt unchanged; rd_pend for address 0 stays 0.
//  6. Both ports valid every cycle for 20 cycles:
//     - exactly one wr per cycle;
//     - grants alternate;
//     - wr_cnt advances by the number of non-zero commits;
//     - with CNT_W=4, wr_cnt wraps from 15 to 0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: two 1-entry writeback slots (ALU, load), age-ordered grant with RR tie-break.
// Latency: accept edge N -> wr high after edge N+1. Backpressure: sN_ready = !full || granted.
module rf_wb_arbiter #(
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int DISCARD_R0 = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [AW-1:0]    s0_addr,
  input  logic [DW-1:0]    s0_data,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic [AW-1:0]    s1_addr,
  input  logic [DW-1:0]    s1_data,
  output logic             wr,
  output logic [AW-1:0]    addr3,
  output logic [DW-1:0]    data3,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic             rd_pend1,
  output logic             rd_pend2,
  output logic [CNT_W-1:0] wr_cnt
);

  logic             r_full0, r_full1;
  logic [AW-1:0]    r_addr0, r_addr1;
  logic [DW-1:0]    r_data0, r_data1;
  logic             r_tie;   // both slots loaded at the same edge
  logic             r_age;   // when not a tie: 1 = slot 1 is older
  logic             r_rr;    // tie winner: 0 = port 0
  logic             r_wr;
  logic [AW-1:0]    r_addr3;
  logic [DW-1:0]    r_data3;
  logic [CNT_W-1:0] r_cnt;

  logic          w_gnt0, w_gnt1, w_acc0, w_acc1, w_nfull0, w_nfull1, w_drop;
  logic [AW-1:0] w_gaddr;
  logic [DW-1:0] w_gdata;

  assign w_gnt0   = r_full0 && (!r_full1 || (r_tie ? !r_rr : !r_age));
  assign w_gnt1   = r_full1 && !w_gnt0;
  assign s0_ready = !r_full0 || w_gnt0;
  assign s1_ready = !r_full1 || w_gnt1;
  assign w_acc0   = s0_valid && s0_ready;
  assign w_acc1   = s1_valid && s1_ready;
  assign w_nfull0 = w_acc0 || (r_full0 && !w_gnt0);
  assign w_nfull1 = w_acc1 || (r_full1 && !w_gnt1);
  assign w_gaddr  = w_gnt0 ? r_addr0 : r_addr1;
  assign w_gdata  = w_gnt0 ? r_data0 : r_data1;
  assign w_drop   = (DISCARD_R0 != 0) && (w_gaddr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full0 <= 1'b0;
      r_full1 <= 1'b0;
      r_addr0 <= '0;
      r_addr1 <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_tie   <= 1'b0;
      r_age   <= 1'b0;
      r_rr    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr3 <= '0;
      r_data3 <= '0;
      r_cnt   <= '0;
    end else begin
      r_full0 <= w_nfull0;
      r_full1 <= w_nfull1;
      if (w_acc0) begin
        r_addr0 <= s0_addr;
        r_data0 <= s0_data;
      end
      if (w_acc1) begin
        r_addr1 <= s1_addr;
        r_data1 <= s1_data;
      end
      // A slot left holding while the other loads becomes the older one.
      if (w_nfull0 && w_nfull1) begin
        if (w_acc0 && w_acc1) begin
          r_tie <= 1'b1;
        end else if (w_acc0) begin
          r_tie <= 1'b0;
          r_age <= 1'b1;
        end else if (w_acc1) begin
          r_tie <= 1'b0;
          r_age <= 1'b0;
        end
      end
      if (r_full0 && r_full1 && r_tie) begin
        r_rr <= ~r_rr;
      end
      if (w_gnt0 || w_gnt1) begin
        r_addr3 <= w_gaddr;
        r_data3 <= w_gdata;
        r_wr    <= !w_drop;
        if (!w_drop) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_wr <= 1'b0;
      end
    end
  end

  assign wr     = r_wr;
  assign addr3  = r_addr3;
  assign data3  = r_data3;
  assign wr_cnt = r_cnt;

  assign rd_pend1 = !((DISCARD_R0 != 0) && (rd_addr1 == '0)) &&
                    ((r_full0 && (r_addr0 == rd_addr1)) ||
                     (r_full1 && (r_addr1 == rd_addr1)) ||
                     (r_wr && (r_addr3 == rd_addr1)));
  assign rd_pend2 = !((DISCARD_R0 != 0) && (rd_addr2 == '0)) &&
                    ((r_full0 && (r_addr0 == rd_addr2)) ||
                     (r_full1 && (r_addr1 == rd_addr2)) ||
                     (r_wr && (r_addr3 == rd_addr2)));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: expected writes are queued when driven and checked when wr rises.
module tb_rf_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wb_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s0_valid, s1_valid, s0_ready, s1_ready;
  logic [AW-1:0] s0_addr, s1_addr, addr3, rd_addr1, rd_addr2;
  logic [DW-1:0] s0_data, s1_data, data3;
  logic          wr, rd_pend1, rd_pend2;
  logic [CW-1:0] wr_cnt;

  rf_wb_arbiter #(.AW(AW), .DW(DW), .DISCARD_R0(1), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .wr(wr), .addr3(addr3), .data3(data3),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_pend1(rd_pend1), .rd_pend2(rd_pend2),
    .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  int      n_cmp = 0;
  int      n_bad = 0;
  wb_t     q[$];
  logic [CW-1:0] exp_cnt = '0;
  bit      s6_on = 1'b0;
  int      cyc = 0;
  int      s6_nwr = 0, s6_first = -1, s6_last = -1;
  bit      wrap_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Writeback monitor: pops the scoreboard on every observed write.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_cnt = '0;
    end else if (wr) begin
      wb_t e;
      exp_cnt = exp_cnt + 1'b1;
      chk("wr_cnt", wr_cnt, exp_cnt);
      if (q.size() == 0) begin
        chk("wr_while_idle", wr, 1'b0);
      end else begin
        e = q.pop_front();
        chk("wb_addr", addr3, e.a);
        chk("wb_data", data3, e.d);
      end
      if (s6_on) begin
        s6_nwr++;
        if (s6_first < 0) s6_first = cyc;
        s6_last = cyc;
        if (wr_cnt == '0) wrap_seen = 1'b1;
      end
    end
  end

  task automatic drv0(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    s0_valid = v; s0_addr = a; s0_data = d;
  endtask

  task automatic drv1(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    s1_valid = v; s1_addr = a; s1_data = d;
  endtask

  initial begin
    wb_t e;
    int  i0, i1;
    bit  a0, a1, done;

    rst_n = 1'b0;
    drv0(1'b0, '0, '0);
    drv1(1'b0, '0, '0);
    rd_addr1 = 5'd3;
    rd_addr2 = 5'd5;
    #1;
    chk("rst_wr", wr, 1'b0);
    chk("rst_addr3", addr3, '0);
    chk("rst_data3", data3, '0);
    chk("rst_wr_cnt", wr_cnt, '0);
    chk("rst_s0_ready", s0_ready, 1'b1);
    chk("rst_s1_ready", s1_ready, 1'b1);
    chk("rst_pend1", rd_pend1, 1'b0);
    chk("rst_pend2", rd_pend2, 1'b0);
    step(); step();
    rst_n = 1'b1;

    // Reset while both slots hold requests
    rd_addr1 = 5'd2;
    drv0(1'b1, 5'd2, 32'h21);
    drv1(1'b1, 5'd4, 32'h41);
    step();
    drv0(1'b0, '0, '0);
    drv1(1'b0, '0, '0);
    chk("t1_pend_full", rd_pend1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t1_async_s0_ready", s0_ready, 1'b1);
    chk("t1_async_s1_ready", s1_ready, 1'b1);
    chk("t1_async_wr", wr, 1'b0);
    chk("t1_async_pend", rd_pend1, 1'b0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("t1_no_write", wr, 1'b0);

    // Single ALU write and its hazard window
    rd_addr1 = 5'd3;
    drv0(1'b1, 5'd3, 32'h11);
    e.a = 5'd3; e.d = 32'h11; q.push_back(e);
    #1;
    chk("t2_ready_pre", s0_ready, 1'b1);
    step();
    drv0(1'b0, '0, '0);
    chk("t2_pend_slot", rd_pend1, 1'b1);
    chk("t2_wr_lat", wr, 1'b0);
    chk("t2_ready_post", s0_ready, 1'b1);
    step();
    chk("t2_wr", wr, 1'b1);
    chk("t2_addr3", addr3, 5'd3);
    chk("t2_data3", data3, 32'h11);
    chk("t2_pend_wr", rd_pend1, 1'b1);
    step();
    chk("t2_wr_drop", wr, 1'b0);
    chk("t2_pend_clear", rd_pend1, 1'b0);

    // Ties: first goes to port 0, repeat tie goes to port 1
    drv0(1'b1, 5'd5, 32'hA);
    drv1(1'b1, 5'd5, 32'hB);
    e.a = 5'd5; e.d = 32'hA; q.push_back(e);
    e.a = 5'd5; e.d = 32'hB; q.push_back(e);
    step();
    drv0(1'b0, '0, '0);
    drv1(1'b0, '0, '0);
    chk("t3_pend2", rd_pend2, 1'b1);
    step(); step(); step();
    drv0(1'b1, 5'd5, 32'h1A);
    drv1(1'b1, 5'd5, 32'h1B);
    e.a = 5'd5; e.d = 32'h1B; q.push_back(e);
    e.a = 5'd5; e.d = 32'h1A; q.push_back(e);
    step();
    drv0(1'b0, '0, '0);
    drv1(1'b0, '0, '0);
    step(); step(); step();

    // Age order: held load slot beats a newer ALU request
    drv0(1'b1, 5'd9, 32'hE0);
    drv1(1'b1, 5'd7, 32'hC);
    e.a = 5'd9; e.d = 32'hE0; q.push_back(e);
    e.a = 5'd7; e.d = 32'hC;  q.push_back(e);
    step();
    drv1(1'b0, '0, '0);
    drv0(1'b1, 5'd7, 32'hD);
    e.a = 5'd7; e.d = 32'hD; q.push_back(e);
    #1;
    chk("t4_s0_ready", s0_ready, 1'b1);
    chk("t4_s1_busy", s1_ready, 1'b0);
    step();
    drv0(1'b0, '0, '0);
    step(); step(); step();

    // Write to r0 is consumed silently
    rd_addr1 = 5'd0;
    drv0(1'b1, 5'd0, 32'hFF);
    step();
    drv0(1'b0, '0, '0);
    chk("t5_pend_r0", rd_pend1, 1'b0);
    step();
    chk("t5_wr", wr, 1'b0);
    chk("t5_wr_cnt", wr_cnt, exp_cnt);
    chk("t5_ready", s0_ready, 1'b1);
    step();
    chk("t5_wr_after", wr, 1'b0);
    chk("t5_drained", q.size(), 0);

    // Both ports streaming from a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      e.a = AW'(k + 1);  e.d = 32'h100 + k; q.push_back(e);
      if (k != 3) begin
        e.a = AW'(k + 16); e.d = 32'h200 + k; q.push_back(e);
      end
    end
    s6_on = 1'b1;
    i0 = 0; i1 = 0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      drv0(i0 < 10, AW'(i0 + 1), 32'h100 + i0);
      drv1(i1 < 10, (i1 == 3) ? AW'(0) : AW'(i1 + 16), 32'h200 + i1);
      #1;
      a0 = s0_valid && s0_ready;
      a1 = s1_valid && s1_ready;
      step();
      if (a0) i0++;
      if (a1) i1++;
      done = (i0 == 10) && (i1 == 10) && (q.size() == 0);
    end
    drv0(1'b0, '0, '0);
    drv1(1'b0, '0, '0);
    s6_on = 1'b0;
    chk("t6_done", done, 1'b1);
    chk("t6_nwr", s6_nwr, 19);
    chk("t6_span", s6_last - s6_first + 1, 20);
    chk("t6_wrap", wrap_seen, 1'b1);
    chk("t6_cnt", wr_cnt, 4'd3);
    chk("t6_queue", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
